// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, default geometry and the edge-selection helper
// used by the oversampled slave.
package spi_pkg;

  localparam int unsigned DEFAULT_WORD_W     = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Encoded as {CPOL, CPHA}.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic [1:0] {
    FRM_LOCKOUT,
    FRM_IDLE,
    FRM_ACTIVE
  } frame_state_e;

  // Modes 0 and 3 sample on the rising sclk edge; modes 1 and 2 on the falling edge.
  function automatic bit sample_on_rise(spi_mode_e mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

endpackage

// File: rtl/spi_slave_oversampled_if.sv
// Pin and stream bundle of the oversampled SPI slave: SPI wires, RX/TX word streams
// and the sticky error flags.
interface spi_slave_oversampled_if
  import spi_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              rx_overrun;
  logic              tx_underrun;
  logic              frame_err;
  logic              flag_clr;

  modport slave (
    input  sclk, cs_n, mosi, rx_ready, tx_data, tx_valid, flag_clr,
    output miso, miso_oe, rx_data, rx_valid, tx_ready, rx_overrun, tx_underrun, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, rx_ready, tx_data, tx_valid, flag_clr,
    input  miso, miso_oe, rx_data, rx_valid, tx_ready, rx_overrun, tx_underrun, frame_err
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push into a full FIFO is accepted only alongside a pop; a pop of
// an empty FIFO is ignored, so nothing ever bypasses the storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: every register written on a clock edge uses <=, so all flops read pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset too, so a freshly reset FIFO presents zeros on rd_data.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_oversampled.sv
// SPI slave clocked entirely by sys_clk: sclk/cs_n/mosi are synchronised and sclk edges
// are detected in the system domain; received and transmitted words pass through FIFOs.
module spi_slave_oversampled
  import spi_pkg::*;
#(
  parameter int              WORD_W     = DEFAULT_WORD_W,
  parameter int              FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter bit              CPOL       = 1'b0,
  parameter bit              CPHA       = 1'b0,
  parameter logic [WORD_W-1:0] TX_IDLE  = '0
) (
  input logic                     sys_clk,
  input logic                     sys_rst,
  spi_slave_oversampled_if.slave  bus
);

  localparam spi_mode_e         MODE        = spi_mode_e'({CPOL, CPHA});
  localparam bit                SAMPLE_RISE = sample_on_rise(MODE);
  localparam int                CNT_W       = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(WORD_W - 1);

  logic [1:0]        sclk_sync, cs_sync, mosi_sync, settle;
  logic              sclk_d;
  logic              sclk_s, cs_n_s, mosi_s;
  logic              sample_edge, shift_edge;
  frame_state_e      state, state_nxt;
  logic              frame_start, frame_end, active;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-2:0] rx_shift;
  logic [WORD_W-1:0] rx_word, tx_shift, tx_head;
  logic              last_bit, do_sample, do_shift, rx_push, tx_load, tx_shift_en;
  logic              rx_full, rx_empty, tx_full, tx_empty, rx_pop_ok;
  logic              overrun_set, underrun_set, frame_err_set;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_sync <= {2{CPOL}};
      sclk_d    <= CPOL;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      settle    <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.sclk};
      sclk_d    <= sclk_sync[1];
      cs_sync   <= {cs_sync[0], bus.cs_n};
      mosi_sync <= {mosi_sync[0], bus.mosi};
      settle    <= {settle[0], 1'b1};
    end
  end

  assign sclk_s      = sclk_sync[1];
  assign cs_n_s      = cs_sync[1];
  assign mosi_s      = mosi_sync[1];
  assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
  assign shift_edge  = SAMPLE_RISE ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);

  // After reset the frame logic waits for the synchronised cs_n to be seen high, so a
  // frame interrupted by reset is never resumed.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= FRM_LOCKOUT;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      FRM_LOCKOUT: if (settle[1] && cs_n_s) state_nxt = FRM_IDLE;
      FRM_IDLE:    if (!cs_n_s) begin
                     state_nxt   = FRM_ACTIVE;
                     frame_start = 1'b1;
                   end
      FRM_ACTIVE:  if (cs_n_s) begin
                     state_nxt = FRM_IDLE;
                     frame_end = 1'b1;
                   end
      default:     state_nxt = FRM_LOCKOUT;
    endcase
  end

  assign active    = (state == FRM_ACTIVE) && !cs_n_s;
  assign do_sample = active & sample_edge;
  assign do_shift  = active & shift_edge;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign rx_word   = {rx_shift, mosi_s};
  assign rx_push   = do_sample & last_bit;

  // CPHA=0 presents the next MSB at the sample edge that closes a word, so the shift edge
  // right after a wrap (bit_cnt back at 0) must not shift. CPHA=1 loads on that edge instead.
  assign tx_load     = CPHA ? (do_shift && bit_cnt == '0) : (frame_start || rx_push);
  assign tx_shift_en = do_shift && (bit_cnt != '0);

  assign rx_pop_ok     = bus.rx_ready & ~rx_empty;
  assign overrun_set   = rx_push & rx_full & ~rx_pop_ok;
  assign underrun_set  = tx_load & tx_empty;
  assign frame_err_set = frame_end && (bit_cnt != '0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt         <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      bus.rx_overrun  <= 1'b0;
      bus.tx_underrun <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      if (!active)        bit_cnt <= '0;
      else if (do_sample) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      if (do_sample) rx_shift <= rx_word[WORD_W-2:0];
      if (tx_load)          tx_shift <= tx_empty ? TX_IDLE : tx_head;
      else if (tx_shift_en) tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
      bus.rx_overrun  <= overrun_set   | (bus.rx_overrun  & ~bus.flag_clr);
      bus.tx_underrun <= underrun_set  | (bus.tx_underrun & ~bus.flag_clr);
      bus.frame_err   <= frame_err_set | (bus.frame_err   & ~bus.flag_clr);
    end
  end

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (rx_push),
    .wr_data (rx_word),
    .pop     (bus.rx_ready),
    .rd_data (bus.rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (bus.tx_valid),
    .wr_data (bus.tx_data),
    .pop     (tx_load),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign bus.miso     = ~cs_n_s & tx_shift[WORD_W-1];
  assign bus.miso_oe  = ~cs_n_s;
  assign bus.rx_valid = ~rx_empty;
  assign bus.tx_ready = ~tx_full;

endmodule
